// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, forwarding
// selects and the writeback-source record compared by the forwarding units.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;

  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [4:0] wa;
    logic       we;
  } wb_src_t;

  // x0 is hardwired, so a write to it never produces a forwardable value
  function automatic logic src_hit(wb_src_t s, logic [4:0] ra);
    return s.we && (s.wa != 5'd0) && (s.wa == ra);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-controller inputs (pipeline register fields) and outputs
// (stage controls, forwarding selects, status counters).
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);

  logic [4:0]       ID_RA1, ID_RA2;
  logic             ID_USE_RS1, ID_USE_RS2;
  logic [4:0]       IDEX_RA1, IDEX_RA2, IDEX_WA;
  logic             IDEX_MemRead;
  logic [4:0]       EXMEM_WA;
  logic             EXMEM_RF_WE;
  logic [4:0]       MEMWB_WA;
  logic             MEMWB_RF_WE;
  logic             EX_REDIRECT;
  logic             D_MEM_REQ, D_MEM_READY;

  logic             PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE;
  logic             IFID_FLUSH, IDEX_BUBBLE, MEMWB_BUBBLE;
  logic [1:0]       FWD_A, FWD_B;
  logic             HALTED;
  logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

  modport master (
    output ID_RA1, ID_RA2, ID_USE_RS1, ID_USE_RS2,
    output IDEX_RA1, IDEX_RA2, IDEX_WA, IDEX_MemRead,
    output EXMEM_WA, EXMEM_RF_WE, MEMWB_WA, MEMWB_RF_WE,
    output EX_REDIRECT, D_MEM_REQ, D_MEM_READY,
    input  PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE,
    input  IFID_FLUSH, IDEX_BUBBLE, MEMWB_BUBBLE,
    input  FWD_A, FWD_B, HALTED, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RA1, ID_RA2, ID_USE_RS1, ID_USE_RS2,
    input  IDEX_RA1, IDEX_RA2, IDEX_WA, IDEX_MemRead,
    input  EXMEM_WA, EXMEM_RF_WE, MEMWB_WA, MEMWB_RF_WE,
    input  EX_REDIRECT, D_MEM_REQ, D_MEM_READY,
    output PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE,
    output IFID_FLUSH, IDEX_BUBBLE, MEMWB_BUBBLE,
    output FWD_A, FWD_B, HALTED, STALL_CNT, FLUSH_CNT
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding comparator for one ALU operand; the younger EX/MEM result wins
// over MEM/WB when both target the same register.
import pipe_ctrl_pkg::*;

module fwd_unit (
  input  wb_src_t    exmem,
  input  wb_src_t    memwb,
  input  logic [4:0] ra,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (src_hit(exmem, ra))      sel = FWD_EXMEM;
    else if (src_hit(memwb, ra)) sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage-register sequencing for the 5-stage pipeline: load-use stalls, EX
// redirects, D-mem wait freeze with watchdog, and stall/flush counters.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  wb_src_t                      exmem_src, memwb_src;
  logic [NUM_OPS-1:0][4:0]      op_ra;
  logic [NUM_OPS-1:0][1:0]      op_fwd;

  assign exmem_src = '{wa: bus.EXMEM_WA, we: bus.EXMEM_RF_WE};
  assign memwb_src = '{wa: bus.MEMWB_WA, we: bus.MEMWB_RF_WE};
  assign op_ra     = {bus.IDEX_RA2, bus.IDEX_RA1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    fwd_unit u_fwd (
      .exmem (exmem_src),
      .memwb (memwb_src),
      .ra    (op_ra[g]),
      .sel   (op_fwd[g])
    );
  end

  assign bus.FWD_A = op_fwd[0];
  assign bus.FWD_B = op_fwd[1];

  logic frozen, load_use, miss;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_bubble, memwb_bubble;
  logic stall_inc, flush_inc;

  assign miss = bus.D_MEM_REQ && !bus.D_MEM_READY;

  // Once waiting, only READY releases the freeze; REQ is not re-qualified
  assign frozen = ((state == RUN) && miss) || ((state == MEM_WAIT) && !bus.D_MEM_READY);

  assign load_use = bus.IDEX_MemRead && (bus.IDEX_WA != 5'd0) &&
                    ((bus.ID_USE_RS1 && (bus.IDEX_WA == bus.ID_RA1)) ||
                     (bus.ID_USE_RS2 && (bus.IDEX_WA == bus.ID_RA2)));

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    memwb_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (state == HALT) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
    end else if (frozen) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
      memwb_bubble = 1'b1;
      stall_inc    = 1'b1;
    end else if (bus.EX_REDIRECT) begin
      // the load-use victim sits in ID and is flushed anyway
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  assign bus.PC_WE        = pc_we;
  assign bus.IFID_WE      = ifid_we;
  assign bus.IDEX_WE      = idex_we;
  assign bus.EXMEM_WE     = exmem_we;
  assign bus.MEMWB_WE     = memwb_we;
  assign bus.IFID_FLUSH   = ifid_flush;
  assign bus.IDEX_BUBBLE  = idex_bubble;
  assign bus.MEMWB_BUBBLE = memwb_bubble;
  assign bus.HALTED       = (state == HALT);
  assign bus.STALL_CNT    = stall_cnt;
  assign bus.FLUSH_CNT    = flush_cnt;

  // wait_cnt counts consecutive frozen cycles, including the initial miss cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
      case (state)
        RUN: begin
          if (miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.D_MEM_READY) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= WCW'(WAIT_TIMEOUT - 1)) begin
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a table of single-cycle control/forwarding vectors, then
// hand sequences for reset, stalls, memory wait and the watchdog.
module tb_pipe_hazard_ctrl;

  logic CLK, RST;
  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {PC,IFID,IDEX,EXMEM,MEMWB}_WE, IFID_FLUSH, IDEX_BUBBLE, MEMWB_BUBBLE, FWD_A, FWD_B
  localparam logic [11:0] O_RUN = 12'b11111_000_00_00;
  localparam logic [11:0] O_FRZ = 12'b00000_001_00_00;
  localparam logic [11:0] O_HLT = 12'b00000_000_00_00;
  localparam logic [11:0] O_LDU = 12'b00111_010_00_00;
  localparam logic [11:0] O_RDR = 12'b11111_110_00_00;

  typedef struct {
    string      name;
    logic [4:0] ra1, ra2;
    logic       use1, use2;
    logic [4:0] iera1, iera2, iewa;
    logic       mrd;
    logic [4:0] emwa;
    logic       emwe;
    logic [4:0] mwwa;
    logic       mwwe;
    logic       redir, req, rdy;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [11:0] outs();
    return {bus.PC_WE, bus.IFID_WE, bus.IDEX_WE, bus.EXMEM_WE, bus.MEMWB_WE,
            bus.IFID_FLUSH, bus.IDEX_BUBBLE, bus.MEMWB_BUBBLE, bus.FWD_A, bus.FWD_B};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clear_in();
    bus.ID_RA1 = 0; bus.ID_RA2 = 0; bus.ID_USE_RS1 = 0; bus.ID_USE_RS2 = 0;
    bus.IDEX_RA1 = 0; bus.IDEX_RA2 = 0; bus.IDEX_WA = 0; bus.IDEX_MemRead = 0;
    bus.EXMEM_WA = 0; bus.EXMEM_RF_WE = 0; bus.MEMWB_WA = 0; bus.MEMWB_RF_WE = 0;
    bus.EX_REDIRECT = 0; bus.D_MEM_REQ = 0; bus.D_MEM_READY = 0;
  endtask

  task automatic drive(input vec_t v);
    bus.ID_RA1 = v.ra1; bus.ID_RA2 = v.ra2; bus.ID_USE_RS1 = v.use1; bus.ID_USE_RS2 = v.use2;
    bus.IDEX_RA1 = v.iera1; bus.IDEX_RA2 = v.iera2; bus.IDEX_WA = v.iewa;
    bus.IDEX_MemRead = v.mrd; bus.EXMEM_WA = v.emwa; bus.EXMEM_RF_WE = v.emwe;
    bus.MEMWB_WA = v.mwwa; bus.MEMWB_RF_WE = v.mwwe; bus.EX_REDIRECT = v.redir;
    bus.D_MEM_REQ = v.req; bus.D_MEM_READY = v.rdy;
  endtask

  task automatic add(input string nm, input logic [4:0] ra1, ra2, input logic use1, use2,
                     input logic [4:0] iera1, iera2, iewa, input logic mrd,
                     input logic [4:0] emwa, input logic emwe,
                     input logic [4:0] mwwa, input logic mwwe,
                     input logic redir, req, rdy, input logic [11:0] exp);
    vec_t v;
    v = '{nm, ra1, ra2, use1, use2, iera1, iera2, iewa, mrd, emwa, emwe, mwwa, mwwe,
          redir, req, rdy, exp};
    vq.push_back(v);
  endtask

  // leaves the bench at a falling edge with reset already applied
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    clear_in();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    clear_in();
    //   name           ra1 ra2 u1 u2 iera1 iera2 iewa mrd emwa emwe mwwa mwwe rdr req rdy exp
    add("idle",          0,  0, 0, 0,   0,    0,   0,  0,   0,  0,   0,  0,   0,  0,  0, O_RUN);
    add("fwd_both_x5",   0,  0, 0, 0,   5,    0,   0,  0,   5,  1,   5,  1,   0,  0,  0, 12'b11111_000_10_00);
    add("fwd_x0",        0,  0, 0, 0,   0,    0,   0,  0,   0,  1,   0,  1,   0,  0,  0, O_RUN);
    add("fwd_memwb_b",   0,  0, 0, 0,   4,    3,   0,  0,   3,  0,   3,  1,   0,  0,  0, 12'b11111_000_00_01);
    add("fwd_exmem_ab",  0,  0, 0, 0,   9,    9,   0,  0,   9,  1,   9,  1,   0,  0,  0, 12'b11111_000_10_10);
    add("fwd_mix",       0,  0, 0, 0,   6,    2,   0,  0,   2,  1,   6,  1,   0,  0,  0, 12'b11111_000_01_10);
    add("ldu_rs2",       0,  7, 0, 1,   0,    0,   7,  1,   0,  0,   0,  0,   0,  0,  0, O_LDU);
    add("ldu_rs1",       7,  0, 1, 0,   0,    0,   7,  1,   0,  0,   0,  0,   0,  0,  0, O_LDU);
    add("ldu_nouse",     7,  7, 0, 0,   0,    0,   7,  1,   0,  0,   0,  0,   0,  0,  0, O_RUN);
    add("ldu_x0",        0,  0, 1, 1,   0,    0,   0,  1,   0,  0,   0,  0,   0,  0,  0, O_RUN);
    add("no_load",       7,  0, 1, 0,   0,    0,   7,  0,   0,  0,   0,  0,   0,  0,  0, O_RUN);
    add("redir_ldu",     0,  7, 0, 1,   0,    0,   7,  1,   0,  0,   0,  0,   1,  0,  0, O_RDR);
    add("req_ready",     0,  0, 0, 0,   0,    0,   0,  0,   0,  0,   0,  0,   0,  1,  1, O_RUN);

    // power-on reset
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_outs",   outs(), O_RUN);
    chk("rst_stall",  bus.STALL_CNT, 0);
    chk("rst_flush",  bus.FLUSH_CNT, 0);
    chk("rst_halted", bus.HALTED, 0);

    foreach (vq[i]) begin
      @(negedge CLK);
      drive(vq[i]);
      #1;
      chk(vq[i].name, outs(), vq[i].exp);
    end

    // load-use: one stall cycle, then the load has moved on
    do_reset();
    bus.IDEX_MemRead = 1; bus.IDEX_WA = 7; bus.ID_RA2 = 7; bus.ID_USE_RS2 = 1;
    #1;
    chk("lu_stall", outs(), O_LDU);
    @(negedge CLK);
    bus.IDEX_MemRead = 0; bus.IDEX_WA = 0; bus.EXMEM_WA = 7; bus.EXMEM_RF_WE = 1;
    #1;
    chk("lu_release", outs(), O_RUN);
    chk("lu_stall_cnt", bus.STALL_CNT, 1);

    // redirect outranks load-use
    do_reset();
    bus.IDEX_MemRead = 1; bus.IDEX_WA = 7; bus.ID_RA2 = 7; bus.ID_USE_RS2 = 1;
    bus.EX_REDIRECT = 1;
    #1;
    chk("rl_outs", outs(), O_RDR);
    @(negedge CLK);
    clear_in();
    #1;
    chk("rl_flush_cnt", bus.FLUSH_CNT, 1);
    chk("rl_stall_cnt", bus.STALL_CNT, 0);

    // memory wait: three frozen cycles, READY lands on the last counter value
    do_reset();
    bus.D_MEM_REQ = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw_frozen%0d", c), outs(), O_FRZ);
      @(negedge CLK);
    end
    bus.D_MEM_READY = 1;
    #1;
    chk("mw_ready", outs(), O_RUN);
    @(negedge CLK);
    bus.D_MEM_REQ = 0; bus.D_MEM_READY = 0;
    #1;
    chk("mw_resumed", outs(), O_RUN);
    chk("mw_stall_cnt", bus.STALL_CNT, 3);

    // watchdog trips after four frozen cycles and stays tripped
    do_reset();
    bus.D_MEM_REQ = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("wd_frozen%0d", c), {outs(), bus.HALTED}, {O_FRZ, 1'b0});
      @(negedge CLK);
    end
    #1;
    chk("wd_halt", {outs(), bus.HALTED}, {O_HLT, 1'b1});
    bus.D_MEM_REQ = 0; bus.D_MEM_READY = 1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("wd_sticky", {outs(), bus.HALTED}, {O_HLT, 1'b1});
    chk("wd_stall_cnt", bus.STALL_CNT, 4);
    do_reset();
    #1;
    chk("wd_cleared", {outs(), bus.HALTED}, {O_RUN, 1'b0});

    // reset while waiting on memory
    do_reset();
    bus.D_MEM_REQ = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    bus.D_MEM_REQ = 0;
    #1;
    chk("rmw_outs", outs(), O_RUN);
    chk("rmw_cnts", {bus.STALL_CNT, bus.FLUSH_CNT}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
